// File: rtl/countdown_timer.sv
// MM:SS countdown engine driven by a one-cycle seconds strobe, with binary and BCD outputs.
// Optional expiry alarm is built only when COUNTDOWN_ALARM_EN is defined.
module countdown_timer #(
   parameter int MAX_MIN    = 59,
   parameter int ALARM_SECS = 5
) (
   input  logic       clock_in,
   input  logic       reset_n,
   input  logic       sec_tick,
   input  logic       load,
   input  logic [5:0] min_in,
   input  logic [5:0] sec_in,
   input  logic       start,
   input  logic       pause,
   output logic [5:0] min_out,
   output logic [5:0] sec_out,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       running,
   output logic       done,
   output logic       expired,
   output logic       alarm
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_t;

   localparam logic [5:0] MAX_MIN_V = 6'(MAX_MIN);

   state_t     r_state;
   state_t     w_next_state;
   logic [5:0] r_min;
   logic [5:0] r_sec;
   logic       r_expired;

   logic [5:0] w_min_clamp;
   logic [5:0] w_sec_clamp;
   logic [5:0] w_dec_min;
   logic [5:0] w_dec_sec;
   logic       w_zero;
   logic       w_dec_zero;
   logic       w_tick_run;
   logic       w_load_ok;
   logic       w_enter_done;

   assign w_min_clamp  = (min_in > MAX_MIN_V) ? MAX_MIN_V : min_in;
   assign w_sec_clamp  = (sec_in > 6'd59) ? 6'd59 : sec_in;
   assign w_zero       = (r_min == 6'd0) && (r_sec == 6'd0);
   assign w_dec_sec    = (r_sec != 6'd0) ? r_sec - 6'd1 : 6'd59;
   assign w_dec_min    = (r_sec != 6'd0) ? r_min : r_min - 6'd1;
   assign w_dec_zero   = (w_dec_min == 6'd0) && (w_dec_sec == 6'd0);
   // The !w_zero guard keeps the count from ever wrapping below 00:00.
   assign w_tick_run   = (r_state == ST_RUN) && sec_tick && !w_zero;
   assign w_load_ok    = load && (r_state != ST_RUN);
   assign w_enter_done = (w_next_state == ST_DONE) && (r_state != ST_DONE);

   always_ff @(posedge clock_in or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves a latch behind.
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!load && !pause && start && !w_zero) w_next_state = ST_RUN;
         end
         ST_RUN: begin
            if (w_tick_run && w_dec_zero) w_next_state = ST_DONE;
            else if (pause)               w_next_state = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (load)                w_next_state = ST_IDLE;
            else if (!pause && start) w_next_state = ST_RUN;
         end
         ST_DONE: begin
            if (load) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_min     <= 6'd0;
         r_sec     <= 6'd0;
         r_expired <= 1'b0;
      end else begin
         if (w_load_ok) begin
            r_min <= w_min_clamp;
            r_sec <= w_sec_clamp;
         end else if (w_tick_run) begin
            r_min <= w_dec_min;
            r_sec <= w_dec_sec;
         end
         r_expired <= w_enter_done;
      end
   end

`ifdef COUNTDOWN_ALARM_EN
   localparam int ACW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;

   logic           r_alarm;
   logic [ACW-1:0] r_alarm_cnt;

   // Counts DONE-state strobes; the strobe that caused expiry happened in RUN and is not counted.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (w_load_ok) begin
         r_alarm     <= 1'b0;
         r_alarm_cnt <= '0;
      end else if (w_enter_done) begin
         r_alarm     <= (ALARM_SECS > 0);
         r_alarm_cnt <= '0;
      end else if ((r_state == ST_DONE) && r_alarm && sec_tick) begin
         if (r_alarm_cnt == ACW'(ALARM_SECS - 1)) r_alarm <= 1'b0;
         else                                     r_alarm_cnt <= r_alarm_cnt + 1'b1;
      end
   end
`else
   logic r_alarm;
   assign r_alarm = 1'b0;
`endif

   always_comb begin
      min_out  = r_min;
      sec_out  = r_sec;
      min_tens = 4'(r_min / 6'd10);
      min_ones = 4'(r_min % 6'd10);
      sec_tens = 4'(r_sec / 6'd10);
      sec_ones = 4'(r_sec % 6'd10);
      running  = (r_state == ST_RUN);
      done     = (r_state == ST_DONE);
      expired  = r_expired;
      alarm    = r_alarm;
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Minutes:seconds countdown engine downstream of the 1 Hz `clock_divider` stage. It consumes a one-cycle seconds strobe and holds a loadable MM:SS value. It decrements on each strobe while running and flags expiry. Binary and BCD digits go out to the display/control logic.

## Interface
Parameters:
- `MAX_MIN`, 59: largest loadable minutes value; larger `min_in` is clamped to it. Legal range 0–63.
- `ALARM_SECS`, 5: number of `sec_tick` strobes `alarm` stays high after expiry. Used only with `COUNTDOWN_ALARM_EN`.

Ports:
- `clock_in`, in, 1: system clock; all logic on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `sec_tick`, in, 1: one-cycle strobe, nominally 1 Hz, synchronous to `clock_in`.
- `load`, in, 1: capture `min_in`/`sec_in` as the preset and remaining time.
- `min_in`, in, 6: preset minutes.
- `sec_in`, in, 6: preset seconds; values above 59 are clamped to 59.
- `start`, in, 1: begin or resume counting (level sampled each cycle).
- `pause`, in, 1: suspend counting.
- `min_out`, out, 6: remaining minutes (binary).
- `sec_out`, out, 6: remaining seconds (binary, 0–59).
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`, out, 4 each: BCD digits of the remaining time.
- `running`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `expired`, out, 1: one-cycle pulse on entry to DONE.
- `alarm`, out, 1: expiry alarm (see Configuration).

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset enters IDLE.
- Command priority in any state: `load` > `pause` > `start`.
- IDLE:
  - `load` captures the clamped preset; stays IDLE.
  - `start` goes to RUN if remaining ≠ 00:00; otherwise it is ignored.
- RUN:
  - `load` is ignored.
  - `pause` goes to PAUSE.
  - On `sec_tick`:
    - if seconds > 0, seconds decrement;
    - else if minutes > 0, minutes decrement and seconds become 59;
    - a decrement that yields 00:00 goes to DONE and pulses `expired`.
- PAUSE:
  - `start` returns to RUN.
  - `load` captures the preset and goes to IDLE.
  - `sec_tick` is ignored.
- DONE:
  - `load` captures the preset and goes to IDLE.
  - `start` is ignored.
- Tick and pause in the same cycle while in RUN: the tick is applied and the state becomes PAUSE. If that decrement reaches 00:00, the state becomes DONE instead, with `expired` pulsing.
- No sub-second phase is tracked. The first decrement occurs on the first `sec_tick` after entering RUN.
- Arithmetic is 6-bit unsigned; counts never wrap below 00:00.
- BCD: tens = value / 10, ones = value % 10. Computed combinationally from the registered counts; minutes up to 63 gives tens 6, ones 3.

## Timing
- Reset values:
  - `min_out` = 0, `sec_out` = 0, all BCD digits = 0.
  - `running` = 0, `done` = 0, `expired` = 0, `alarm` = 0.
- Asserting `reset_n` low mid-count clears everything immediately; a count in progress is lost.
- `min_out`/`sec_out` update on the clock edge that samples `sec_tick`, so the new value is visible the cycle after the strobe. The BCD digits change in the same cycle.
- `running` and `done` are registered state decodes, valid from the cycle after the transition.
- `expired` is high for exactly one cycle: the first cycle in which `done` = 1.
- `load` takes effect in the following cycle.

## Configuration
- `COUNTDOWN_ALARM_EN` defined:
  - `alarm` rises together with `expired`;
  - it stays high for `ALARM_SECS` `sec_tick` strobes counted while in DONE, then falls;
  - `load` or reset clears it at once.
- Not defined: `alarm` is tied to 0 and no alarm counter is built. `done`/`expired` are unchanged.

## Test plan
- Reset value check: hold `reset_n` low with garbage inputs -> all outputs read 0 and the state is IDLE; release -> `start` is ignored because remaining is 00:00.
- Rollover and expiry: load 01:02, start, 63 ticks:
  - reads 01:01 and 01:00, then 00:59 (BCD 0,0,5,9);
  - reaches 00:00 on the 62nd tick, with a single `expired` pulse and `done` = 1;
  - the 63rd tick causes no change.
- Clamping: load `min_in` = 63, `sec_in` = 61 with default `MAX_MIN` -> 59:59, BCD 5,9,5,9.
- Pause behaviour:
  - load 00:10, start, 3 ticks, pause plus tick in the same cycle -> 00:06 in PAUSE;
  - 5 further ticks -> still 00:06;
  - start -> RUN.
- Load in RUN ignored, load in DONE accepted:
  - load during RUN -> count unaffected;
  - load 00:03 in DONE -> IDLE at 00:03 with `done` = 0.
- Alarm, built with `COUNTDOWN_ALARM_EN` and `ALARM_SECS` = 5: expiry -> `alarm` high for 5 ticks, then low; without the macro, `alarm` stays 0 throughout.
